// File: rtl/cache_2way.sv
// Two-way set-associative write-back cache in front of a 64-bit burst RAM.
// Defining CACHE_2WAY_STATS_EN adds the hit_count/miss_count outputs.
module cache_2way #(
  parameter int LINE_IX_BITWIDTH         = 1,
  parameter int BURST_RAM_DEPTH_BITWIDTH = 5,
  parameter int BURST_COUNT              = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic [31:0]                         address,
  input  logic [31:0]                         data_in,
  input  logic [3:0]                          write_enable,
  output logic [31:0]                         data_out,
  output logic                                data_out_ready,
  output logic                                busy,
  output logic                                br_cmd,
  output logic                                br_cmd_en,
  output logic [BURST_RAM_DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]                         br_wr_data,
  output logic [7:0]                          br_data_mask,
  input  logic [63:0]                         br_rd_data,
  input  logic                                br_rd_data_ready,
  input  logic                                br_busy
`ifdef CACHE_2WAY_STATS_EN
  ,
  output logic [31:0]                         hit_count,
  output logic [31:0]                         miss_count
`endif
);

  localparam int WORDS     = BURST_COUNT * 2;
  localparam int WORD_BITS = $clog2(WORDS);
  localparam int BEAT_BITS = $clog2(BURST_COUNT);
  localparam int SETS      = 1 << LINE_IX_BITWIDTH;
  localparam int SET_LSB   = 2 + WORD_BITS;
  localparam int TAG_LSB   = SET_LSB + LINE_IX_BITWIDTH;
  localparam int ADDR_TOP  = BURST_RAM_DEPTH_BITWIDTH + 3;
  localparam int TAG_BITS  = ADDR_TOP - TAG_LSB;

  typedef enum logic [2:0] {IDLE, WB_CMD, WB_DATA, FILL_CMD, FILL_DATA, REPLAY} state_t;

  state_t                      state_q, state_d;
  logic [BEAT_BITS-1:0]        beat_q, beat_d;
  logic                        victim_q, victim_d;
  logic [LINE_IX_BITWIDTH-1:0] req_set_q, req_set_d;
  logic [WORD_BITS-1:0]        req_word_q, req_word_d;
  logic [TAG_BITS-1:0]         req_tag_q, req_tag_d;
  logic [31:0]                 req_data_q, req_data_d;
  logic [3:0]                  req_we_q, req_we_d;
  logic [1:0]                  valid_q [SETS];
  logic [1:0]                  valid_d [SETS];
  logic [1:0]                  dirty_q [SETS];
  logic [1:0]                  dirty_d [SETS];
  logic [TAG_BITS-1:0]         tag_q [SETS][2];
  logic [TAG_BITS-1:0]         tag_d [SETS][2];
  logic [SETS-1:0]             lru_q, lru_d;
  logic [31:0]                 data_q [SETS][2][WORDS];
  logic [31:0]                 data_d [SETS][2][WORDS];
  logic [31:0]                 data_out_q, data_out_d;
  logic                        data_out_ready_q, data_out_ready_d;

  logic [LINE_IX_BITWIDTH-1:0] in_set, acc_set;
  logic [WORD_BITS-1:0]        in_word, acc_word;
  logic [TAG_BITS-1:0]         in_tag;
  logic [31:0]                 acc_data;
  logic [3:0]                  acc_we;
  logic [1:0]                  hit_vec;
  logic                        hit, hit_way, pick_victim, acc_way, access;
  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] wb_base, fill_base;
  logic                        unused_addr_bits;

  assign in_word = address[SET_LSB-1:2];
  assign in_set  = address[TAG_LSB-1:SET_LSB];
  assign in_tag  = address[ADDR_TOP-1:TAG_LSB];
  assign unused_addr_bits = ^{address[31:ADDR_TOP], address[1:0]};

  assign hit_vec[0]  = valid_q[in_set][0] && (tag_q[in_set][0] == in_tag);
  assign hit_vec[1]  = valid_q[in_set][1] && (tag_q[in_set][1] == in_tag);
  assign hit         = |hit_vec;
  assign hit_way     = hit_vec[1];
  assign pick_victim = !valid_q[in_set][0] ? 1'b0 :
                       !valid_q[in_set][1] ? 1'b1 : lru_q[in_set];

  // A hit in IDLE and the replay after a fill share one access path.
  assign access   = ((state_q == IDLE) && enable && hit) || (state_q == REPLAY);
  assign acc_set  = (state_q == IDLE) ? in_set       : req_set_q;
  assign acc_word = (state_q == IDLE) ? in_word      : req_word_q;
  assign acc_data = (state_q == IDLE) ? data_in      : req_data_q;
  assign acc_we   = (state_q == IDLE) ? write_enable : req_we_q;
  assign acc_way  = (state_q == IDLE) ? hit_way      : victim_q;

  assign wb_base   = {tag_q[req_set_q][victim_q], req_set_q, {BEAT_BITS{1'b0}}};
  assign fill_base = {req_tag_q, req_set_q, {BEAT_BITS{1'b0}}};

  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    victim_d         = victim_q;
    req_set_d        = req_set_q;
    req_word_d       = req_word_q;
    req_tag_d        = req_tag_q;
    req_data_d       = req_data_q;
    req_we_d         = req_we_q;
    valid_d          = valid_q;
    dirty_d          = dirty_q;
    tag_d            = tag_q;
    lru_d            = lru_q;
    data_d           = data_q;
    data_out_d       = data_out_q;
    data_out_ready_d = 1'b0;
    br_cmd           = 1'b0;
    br_cmd_en        = 1'b0;
    br_addr          = '0;
    br_wr_data       = '0;

    case (state_q)
      IDLE: begin
        if (enable && !hit) begin
          req_set_d  = in_set;
          req_word_d = in_word;
          req_tag_d  = in_tag;
          req_data_d = data_in;
          req_we_d   = write_enable;
          victim_d   = pick_victim;
          beat_d     = '0;
          state_d    = (valid_q[in_set][pick_victim] && dirty_q[in_set][pick_victim])
                       ? WB_CMD : FILL_CMD;
        end
      end
      WB_CMD: begin
        if (!br_busy) begin
          br_cmd     = 1'b1;
          br_cmd_en  = 1'b1;
          br_addr    = wb_base;
          br_wr_data = {data_q[req_set_q][victim_q][1], data_q[req_set_q][victim_q][0]};
          beat_d     = BEAT_BITS'(1);
          state_d    = WB_DATA;
        end
      end
      WB_DATA: begin
        br_wr_data = {data_q[req_set_q][victim_q][{beat_q, 1'b1}],
                      data_q[req_set_q][victim_q][{beat_q, 1'b0}]};
        if (beat_q == BEAT_BITS'(BURST_COUNT - 1)) begin
          beat_d  = '0;
          state_d = FILL_CMD;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      FILL_CMD: begin
        if (!br_busy) begin
          br_cmd_en = 1'b1;
          br_addr   = fill_base;
          beat_d    = '0;
          state_d   = FILL_DATA;
        end
      end
      FILL_DATA: begin
        if (br_rd_data_ready) begin
          data_d[req_set_q][victim_q][{beat_q, 1'b0}] = br_rd_data[31:0];
          data_d[req_set_q][victim_q][{beat_q, 1'b1}] = br_rd_data[63:32];
          if (beat_q == BEAT_BITS'(BURST_COUNT - 1)) begin
            valid_d[req_set_q][victim_q] = 1'b1;
            dirty_d[req_set_q][victim_q] = 1'b0;
            tag_d[req_set_q][victim_q]   = req_tag_q;
            state_d                      = REPLAY;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      REPLAY: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (access) begin
      lru_d[acc_set] = ~acc_way;
      if (acc_we == 4'b0000) begin
        data_out_d       = data_q[acc_set][acc_way][acc_word];
        data_out_ready_d = 1'b1;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (acc_we[b]) data_d[acc_set][acc_way][acc_word][8*b +: 8] = acc_data[8*b +: 8];
        end
        dirty_d[acc_set][acc_way] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      beat_q           <= '0;
      victim_q         <= 1'b0;
      req_set_q        <= '0;
      req_word_q       <= '0;
      req_tag_q        <= '0;
      req_data_q       <= '0;
      req_we_q         <= '0;
      valid_q          <= '{default: '0};
      dirty_q          <= '{default: '0};
      lru_q            <= '0;
      data_out_q       <= '0;
      data_out_ready_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      beat_q           <= beat_d;
      victim_q         <= victim_d;
      req_set_q        <= req_set_d;
      req_word_q       <= req_word_d;
      req_tag_q        <= req_tag_d;
      req_data_q       <= req_data_d;
      req_we_q         <= req_we_d;
      valid_q          <= valid_d;
      dirty_q          <= dirty_d;
      lru_q            <= lru_d;
      data_out_q       <= data_out_d;
      data_out_ready_q <= data_out_ready_d;
    end
  end

  // Tags and line data are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign data_out       = data_out_q;
  assign data_out_ready = data_out_ready_q;
  assign busy           = (state_q != IDLE);
  assign br_data_mask   = '0;

`ifdef CACHE_2WAY_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if ((state_q == IDLE) && enable) begin
      if (hit) hit_count_d  = hit_count_q + 32'd1;
      else     miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_2way.sv
// Scoreboard bench for cache_2way: directed requests against a burst-RAM model
// whose 32-bit word at byte A initially holds A.
module tb_cache_2way;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [3:0]  write_enable;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;
  logic        br_cmd;
  logic        br_cmd_en;
  logic [4:0]  br_addr;
  logic [63:0] br_wr_data;
  logic [7:0]  br_data_mask;
  logic [63:0] br_rd_data;
  logic        br_rd_data_ready;
  logic        br_busy;
`ifdef CACHE_2WAY_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_data [$];
  logic [5:0]  exp_br [$];
  logic [31:0] mon_exp;
  logic [5:0]  mon_br;

  cache_2way dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .address          (address),
    .data_in          (data_in),
    .write_enable     (write_enable),
    .data_out         (data_out),
    .data_out_ready   (data_out_ready),
    .busy             (busy),
    .br_cmd           (br_cmd),
    .br_cmd_en        (br_cmd_en),
    .br_addr          (br_addr),
    .br_wr_data       (br_wr_data),
    .br_data_mask     (br_data_mask),
    .br_rd_data       (br_rd_data),
    .br_rd_data_ready (br_rd_data_ready),
    .br_busy          (br_busy)
`ifdef CACHE_2WAY_STATS_EN
    ,
    .hit_count        (hit_count),
    .miss_count       (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Burst RAM model: reads return after two idle cycles with a gap after beat 1;
  // br_busy lingers one cycle after a write burst so the fill must wait.
  logic [63:0] mem [32];
  logic        mem_loaded = 1'b0;
  logic [4:0]  wr_addr, rd_addr;
  logic [1:0]  wr_cnt, rd_ptr, rd_delay;
  logic        wr_tail, rd_active;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (!mem_loaded) begin
        for (int i = 0; i < 32; i++) mem[i] <= {32'(8 * i + 4), 32'(8 * i)};
        mem_loaded <= 1'b1;
      end
      wr_addr          <= '0;
      rd_addr          <= '0;
      wr_cnt           <= '0;
      rd_ptr           <= '0;
      rd_delay         <= '0;
      wr_tail          <= 1'b0;
      rd_active        <= 1'b0;
      br_busy          <= 1'b0;
      br_rd_data       <= '0;
      br_rd_data_ready <= 1'b0;
    end else begin
      br_rd_data_ready <= 1'b0;
      if (br_cmd_en && br_cmd) begin
        mem[br_addr] <= br_wr_data;
        wr_addr      <= br_addr;
        wr_cnt       <= 2'd1;
        br_busy      <= 1'b1;
      end else if (wr_cnt != 2'd0) begin
        mem[wr_addr + {3'b000, wr_cnt}] <= br_wr_data;
        wr_cnt <= wr_cnt + 2'd1;
        if (wr_cnt == 2'd3) wr_tail <= 1'b1;
      end else if (wr_tail) begin
        wr_tail <= 1'b0;
        br_busy <= 1'b0;
      end
      if (br_cmd_en && !br_cmd) begin
        rd_addr   <= br_addr;
        rd_ptr    <= 2'd0;
        rd_delay  <= 2'd2;
        rd_active <= 1'b1;
        br_busy   <= 1'b1;
      end else if (rd_active) begin
        if (rd_delay != 2'd0) begin
          rd_delay <= rd_delay - 2'd1;
        end else begin
          br_rd_data       <= mem[rd_addr + {3'b000, rd_ptr}];
          br_rd_data_ready <= 1'b1;
          rd_ptr           <= rd_ptr + 2'd1;
          if (rd_ptr == 2'd1) rd_delay <= 2'd1;
          if (rd_ptr == 2'd3) begin
            rd_active <= 1'b0;
            br_busy   <= 1'b0;
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic flag_failure(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout, expected completion", name);
  endtask

  // Monitor: every completed read and every burst command is matched in order.
  always @(negedge clk) begin
    if (rst_n && data_out_ready) begin
      if (exp_data.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ready: got 0x%08h, expected no completion", data_out);
      end else begin
        mon_exp = exp_data.pop_front();
        check_output("read_data", data_out, mon_exp);
      end
    end
    if (rst_n && br_cmd_en) begin
      if (exp_br.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_br_cmd: got cmd=%0b addr=%0d, expected none", br_cmd, br_addr);
      end else begin
        mon_br = exp_br.pop_front();
        check_output("br_cmd_addr", {26'b0, br_cmd, br_addr}, {26'b0, mon_br});
      end
    end
  end

  task automatic apply_stimulus(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] we, input logic [31:0] exp_rd, input logic exp_miss);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    address      = addr;
    data_in      = wdata;
    write_enable = we;
    enable       = 1'b1;
    if (we == 4'b0000) exp_data.push_back(exp_rd);
    @(negedge clk);
    check_output({name, "_busy"}, {31'b0, busy}, {31'b0, exp_miss});
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) flag_failure({name, "_timeout"});
    enable = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check_output({name, "_data_out"}, data_out, 32'h0);
    check_output({name, "_ready_busy"}, {30'b0, data_out_ready, busy}, 32'h0);
    check_output({name, "_br_ctrl"}, {25'b0, br_cmd, br_cmd_en, br_addr}, 32'h0);
    check_output({name, "_br_wr_lo"}, br_wr_data[31:0], 32'h0);
    check_output({name, "_br_wr_hi"}, br_wr_data[63:32], 32'h0);
    check_output({name, "_br_mask"}, {24'b0, br_data_mask}, 32'h0);
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    enable       = 1'b0;
    address      = '0;
    data_in      = '0;
    write_enable = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
`ifdef CACHE_2WAY_STATS_EN
    check_output("reset_hit_count", hit_count, 32'd0);
    check_output("reset_miss_count", miss_count, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    exp_br.push_back({1'b0, 5'd0});
    apply_stimulus("rd_10_miss", 32'h10, 32'h0, 4'b0000, 32'h0000_0010, 1'b1);
    apply_stimulus("rd_14_hit", 32'h14, 32'h0, 4'b0000, 32'h0000_0014, 1'b0);

    exp_br.push_back({1'b0, 5'd8});
    apply_stimulus("wr_40_miss", 32'h40, 32'hABCD_EF12, 4'b1111, 32'h0, 1'b1);
    apply_stimulus("rd_40_hit", 32'h40, 32'h0, 4'b0000, 32'hABCD_EF12, 1'b0);

    apply_stimulus("rd_04_hit", 32'h04, 32'h0, 4'b0000, 32'h0000_0004, 1'b0);
    exp_br.push_back({1'b1, 5'd8});
    exp_br.push_back({1'b0, 5'd16});
    apply_stimulus("rd_80_evict", 32'h80, 32'h0, 4'b0000, 32'h0000_0080, 1'b1);
    exp_br.push_back({1'b0, 5'd8});
    apply_stimulus("rd_40_refill", 32'h40, 32'h0, 4'b0000, 32'hABCD_EF12, 1'b1);
`ifdef CACHE_2WAY_STATS_EN
    check_output("hit_count", hit_count, 32'd3);
    check_output("miss_count", miss_count, 32'd4);
`endif

    exp_br.push_back({1'b0, 5'd0});
    apply_stimulus("wr_14_byte0", 32'h14, 32'h0000_00AD, 4'b0001, 32'h0, 1'b1);
    apply_stimulus("rd_14_merged", 32'h14, 32'h0, 4'b0000, 32'h0000_00AD, 1'b0);

    // Reset while the fill of 0x20 is streaming in.
    address      = 32'h20;
    data_in      = 32'h0;
    write_enable = 4'b0000;
    enable       = 1'b1;
    exp_br.push_back({1'b0, 5'd4});
    @(negedge clk);
    check_output("rd_20_busy", {31'b0, busy}, 32'd1);
    n = 0;
    while (br_rd_data_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) flag_failure("rd_20_fill_wait");
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midfill_reset");
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    exp_br.push_back({1'b0, 5'd4});
    apply_stimulus("rd_20_after_reset", 32'h20, 32'h0, 4'b0000, 32'h0000_0020, 1'b1);
    exp_br.push_back({1'b0, 5'd0});
    apply_stimulus("rd_14_dirty_lost", 32'h14, 32'h0, 4'b0000, 32'h0000_0014, 1'b1);
    apply_stimulus("wr_18_mid_bytes", 32'h18, 32'h1234_5678, 4'b0110, 32'h0, 1'b0);
    apply_stimulus("rd_18_merged", 32'h18, 32'h0, 4'b0000, 32'h0034_5618, 1'b0);
    apply_stimulus("rd_1c_last_word", 32'h1C, 32'h0, 4'b0000, 32'h0000_001C, 1'b0);

    repeat (5) @(negedge clk);
    check_output("pending_reads", 32'(exp_data.size()), 32'd0);
    check_output("pending_bursts", 32'(exp_br.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/cache_2way.md
CACHE_2WAY -- requirements
Module: cache_2way

Interface
REQ-001 SHALL have parameter LINE_IX_BITWIDTH, default 1, meaning log2 of number of sets.
REQ-002 SHALL have parameter BURST_RAM_DEPTH_BITWIDTH, default 5, meaning log2 of burst-RAM depth in 8-byte words.
REQ-003 SHALL have parameter BURST_COUNT, default 4, meaning 64-bit beats per burst; line = BURST_COUNT*8 bytes; power of 2, >=2.
REQ-004 SHALL have port clk, input, 1, meaning the single clock.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have ports enable in 1 (request valid); address in 32 (byte address); data_in in 32; write_enable in 4 (byte strobes, 0 = read).
REQ-007 SHALL have ports data_out out 32, data_out_ready out 1, busy out 1.
REQ-008 SHALL have burst-RAM ports br_cmd out 1 (0 read, 1 write), br_cmd_en out 1, br_addr out BURST_RAM_DEPTH_BITWIDTH, br_wr_data out 64, br_data_mask out 8, br_rd_data in 64, br_rd_data_ready in 1, br_busy in 1.

Function
REQ-009 SHALL decode address: [1:0] byte, next log2(BURST_COUNT*2) bits word-in-line, next LINE_IX_BITWIDTH bits set, remaining bits up to BURST_RAM_DEPTH_BITWIDTH+3 tag; higher bits ignored.
REQ-010 SHALL hold per set two ways, each with valid, dirty, tag and line data, plus one LRU bit naming the least-recently-used way.
REQ-011 SHALL accept a request only when enable=1 and busy=0.
REQ-012 SHALL on read hit drive data_out and data_out_ready=1 on the next cycle, busy staying 0; data_out_ready SHALL be 1 for exactly one cycle per completed read.
REQ-013 SHALL on write hit merge only strobed bytes into the word, set dirty, complete next cycle with data_out_ready=0, busy staying 0.
REQ-014 SHALL on any hit set LRU to the other way.
REQ-015 SHALL on miss assert busy from the next cycle until the request completes and latch address, data_in, write_enable.
REQ-016 SHALL choose victim as the first invalid way (way 0 before way 1), else the LRU way.
REQ-017 SHALL use states IDLE, WB_CMD, WB_DATA, FILL_CMD, FILL_DATA, REPLAY; miss goes to WB_CMD if victim valid and dirty, else FILL_CMD.
REQ-018 SHALL in WB_CMD wait for br_busy=0, then for one cycle assert br_cmd=1, br_cmd_en=1, br_addr = victim line base, br_wr_data = beat 0; WB_DATA SHALL drive beats 1..BURST_COUNT-1 on consecutive cycles, then go to FILL_CMD.
REQ-019 SHALL in FILL_CMD wait for br_busy=0, then assert br_cmd=0, br_cmd_en=1 for one cycle with the requested line base; FILL_DATA SHALL store one beat per br_rd_data_ready cycle in ascending order.
REQ-020 SHALL after the last beat set valid=1, dirty=0, tag, enter REPLAY, and there complete the latched request exactly as a hit (REQ-012..014), then return to IDLE with busy=0.
REQ-021 SHALL drive br_data_mask=0 always and br_cmd_en=0 outside REQ-018/019 cycles.
REQ-022 SHALL treat 64-bit beat lanes as little-endian: 32-bit word 2k in bits [31:0], word 2k+1 in bits [63:32].
REQ-023 SHALL ignore enable while busy=1; requester holds inputs stable until busy falls.

Reset
REQ-024 SHALL on rst_n=0 immediately clear all valid, dirty and LRU bits, enter IDLE, and drive data_out=0, data_out_ready=0, busy=0, br_cmd=0, br_cmd_en=0, br_addr=0, br_wr_data=0.
REQ-025 SHALL on reset mid-burst abandon the transfer; dirty data in flight is lost; line data contents need not be reset.

Configuration
REQ-026 SHALL with macro CACHE_2WAY_STATS_EN defined add outputs hit_count 32 and miss_count 32, reset to 0, incremented once per accepted hit / miss, wrapping at 2^32-1; REPLAY SHALL not count as a hit.
REQ-027 SHALL without CACHE_2WAY_STATS_EN have no such ports and no counter logic.

Verification (defaults; RAM preloaded so 32-bit word at byte A equals A)
REQ-028 After reset, read 0x10 -> busy next cycle, one read burst br_addr=0 with 4 beats, data_out=0x00000010 with data_out_ready; then read 0x14 -> data_out=0x00000014 next cycle, busy never 1.
REQ-029 Write 0x40, data_in=0xABCDEF12, write_enable=1111 -> fill into way 1, no br write; read 0x40 -> 0xABCDEF12.
REQ-030 Read 0x04, then read 0x80 -> evict dirty line 0x40: write burst br_addr=8, 4 beats, then read burst br_addr=16, data 0x00000080; read 0x40 -> miss, data 0xABCDEF12.
REQ-031 Write 0x14, data_in=0x000000AD, write_enable=0001 -> read 0x14 returns 0x000000AD.
REQ-032 rst_n=0 during FILL_DATA -> all outputs 0 at once; after release read same address -> full miss sequence again.
REQ-033 With CACHE_2WAY_STATS_EN, sequence REQ-028..030 -> hit_count=3, miss_count=4.
